// File: rtl/arriskv_pkg.sv
// Shared decode/execute types for the arriskv core: decoded op layout, opcodes and
// small helpers used by the pipeline blocks.
package arriskv_pkg;

  localparam int XLEN        = 32;
  localparam int QUEUE_DEPTH = 4;

  typedef enum logic [3:0] {
    NOP  = 4'd0,
    ADD  = 4'd1,
    ADDI = 4'd2,
    LW   = 4'd3,
    SW   = 4'd4,
    JAL  = 4'd5,
    BEQ  = 4'd6
  } opcode_t;

  typedef struct packed {
    opcode_t         op;
    logic [4:0]      rdest;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] arg1;
    logic [XLEN-1:0] arg2;
    logic [XLEN-1:0] imm_se;
  } decoded_op_t;

  typedef logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_cnt_t;

  function automatic logic is_nop(decoded_op_t o);
    return o.op == NOP;
  endfunction

endpackage

// File: rtl/arriskv_rdest_match.sv
// Comparator array: flags each hazard query port whose register is written by any
// valid queued entry. Register 0 never reports a hazard.
module arriskv_rdest_match #(
  parameter int DEPTH     = 4,
  parameter int HAZ_PORTS = 2
) (
  input  logic [DEPTH-1:0]     ent_valid,
  input  logic [DEPTH*5-1:0]   ent_rdest,
  input  logic [HAZ_PORTS*5-1:0] hz_rs,
  output logic [HAZ_PORTS-1:0] hz_busy
);

  always_comb begin
    hz_busy = '0;
    for (int p = 0; p < HAZ_PORTS; p++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_valid[e] && (hz_rs[p*5 +: 5] != 5'd0) &&
            (ent_rdest[e*5 +: 5] == hz_rs[p*5 +: 5])) begin
          hz_busy[p] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arriskv_op_queue.sv
// Decode-to-execute op FIFO with flush, optional empty-queue bypass, NOP dropping
// and RAW hazard reporting on queued destination registers.
module arriskv_op_queue
  import arriskv_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int HAZ_PORTS = 2,
  parameter int BYPASS    = 1,
  parameter int DROP_NOP  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  decoded_op_t                  in_op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output decoded_op_t                  out_op,
  input  logic [HAZ_PORTS*5-1:0]       hz_rs,
  output logic [HAZ_PORTS-1:0]         hz_busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);

  decoded_op_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty, drop_nop, byp_active, bypass_take, push, pop;
  logic [DEPTH-1:0]   ent_valid;
  logic [DEPTH*5-1:0] ent_rdest;

  assign empty       = (count_q == '0);
  assign in_ready    = (count_q != DEPTH_C);
  assign drop_nop    = (DROP_NOP != 0) && is_nop(in_op);
  assign byp_active  = (BYPASS != 0) && empty && !flush;
  assign bypass_take = byp_active && in_valid && out_ready && !drop_nop;
  assign push        = in_valid && in_ready && !flush && !drop_nop && !bypass_take;
  assign pop         = out_valid && out_ready && !empty;
  assign count       = count_q;

  always_comb begin
    out_valid = 1'b0;
    out_op    = mem_q[rd_ptr_q];
    if (!flush) begin
      if (byp_active) begin
        out_valid = in_valid && !drop_nop;
        out_op    = in_op;
      end else begin
        out_valid = !empty;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_op;
  end

  // An entry is live when its distance from rd_ptr (mod DEPTH) is below count.
  always_comb begin
    ent_valid = '0;
    ent_rdest = '0;
    for (int e = 0; e < DEPTH; e++) begin
      int off;
      off = e - int'(rd_ptr_q);
      if (off < 0) off = off + DEPTH;
      ent_valid[e]       = (off < int'(count_q));
      ent_rdest[e*5 +: 5] = mem_q[e].rdest;
    end
  end

  arriskv_rdest_match #(
    .DEPTH     (DEPTH),
    .HAZ_PORTS (HAZ_PORTS)
  ) u_rdest_match (
    .ent_valid (ent_valid),
    .ent_rdest (ent_rdest),
    .hz_rs     (hz_rs),
    .hz_busy   (hz_busy)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (count_q != DEPTH_C));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && out_ready && empty) |-> byp_active);

endmodule

// File: tb/tb_arriskv_op_queue.sv
// Bench for arriskv_op_queue: two configurations driven in parallel, checked every
// cycle against a queue-based model plus directed literal expectations.
module tb_arriskv_op_queue;
  import arriskv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, out_ready;
  decoded_op_t in_op;
  logic [9:0]  hz_rs;

  logic        nb_in_ready, nb_out_valid, by_in_ready, by_out_valid;
  decoded_op_t nb_out_op, by_out_op;
  logic [1:0]  nb_hz_busy, by_hz_busy;
  logic [1:0]  nb_count;
  logic [2:0]  by_count;

  int errors = 0;
  int checks = 0;

  decoded_op_t mq_nb[$];
  decoded_op_t mq_by[$];

  always #5 clk = ~clk;

  arriskv_op_queue #(.DEPTH(3), .HAZ_PORTS(2), .BYPASS(0), .DROP_NOP(1)) u_nb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(nb_in_ready),
    .in_op(in_op), .out_valid(nb_out_valid), .out_ready(out_ready), .out_op(nb_out_op),
    .hz_rs(hz_rs), .hz_busy(nb_hz_busy), .count(nb_count));

  arriskv_op_queue #(.DEPTH(4), .HAZ_PORTS(2), .BYPASS(1), .DROP_NOP(1)) u_by (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(by_in_ready),
    .in_op(in_op), .out_valid(by_out_valid), .out_ready(out_ready), .out_op(by_out_op),
    .hz_rs(hz_rs), .hz_busy(by_hz_busy), .count(by_count));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_op(input string nm, input decoded_op_t act, input decoded_op_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic decoded_op_t mkop(input opcode_t op, input int rd, input int imm);
    decoded_op_t o;
    o.op     = op;
    o.rdest  = 5'(rd);
    o.rs1    = 5'(rd + 1);
    o.rs2    = 5'(rd + 2);
    o.arg1   = 32'(imm * 3);
    o.arg2   = 32'(imm ^ 32'h5a5a);
    o.imm_se = 32'(imm);
    return o;
  endfunction

  // Model: queue contents plus the handshake rules give every expected output.
  task automatic cmp_inst(input string tag, input decoded_op_t q[$], input int depth,
                          input bit byp, input logic ir, input logic ov,
                          input decoded_op_t oo, input logic [1:0] hb, input int cnt);
    bit          e_ov;
    decoded_op_t e_oo;
    logic [1:0]  e_hb;
    e_ov = 1'b0;
    e_oo = '0;
    if (!flush) begin
      if (byp && q.size() == 0) begin
        e_ov = in_valid && (in_op.op != NOP);
        e_oo = in_op;
      end else if (q.size() > 0) begin
        e_ov = 1'b1;
        e_oo = q[0];
      end
    end
    for (int i = 0; i < 2; i++) begin
      e_hb[i] = 1'b0;
      foreach (q[j]) if (hz_rs[i*5 +: 5] != 5'd0 && q[j].rdest == hz_rs[i*5 +: 5]) e_hb[i] = 1'b1;
    end
    chk({tag, ".in_ready"}, ir, (q.size() < depth) ? 1 : 0);
    chk({tag, ".out_valid"}, ov, e_ov);
    chk({tag, ".count"}, cnt, q.size());
    chk({tag, ".hz_busy"}, hb, e_hb);
    if (e_ov) chk_op({tag, ".out_op"}, oo, e_oo);
  endtask

  function automatic void moves(input int sz, input int depth, input bit byp,
                                output bit pu, output bit po);
    bit nop, ov, take;
    nop  = (in_op.op == NOP);
    ov   = !flush && ((byp && sz == 0) ? (in_valid && !nop) : (sz > 0));
    take = byp && sz == 0 && !flush && in_valid && out_ready && !nop;
    po   = !flush && ov && out_ready && sz > 0;
    pu   = !flush && in_valid && (sz < depth) && !nop && !take;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit pu, po;
    if (!rst_n) begin
      mq_nb.delete();
      mq_by.delete();
    end else if (flush) begin
      mq_nb.delete();
      mq_by.delete();
    end else begin
      moves(mq_nb.size(), 3, 1'b0, pu, po);
      if (po) void'(mq_nb.pop_front());
      if (pu) mq_nb.push_back(in_op);
      moves(mq_by.size(), 4, 1'b1, pu, po);
      if (po) void'(mq_by.pop_front());
      if (pu) mq_by.push_back(in_op);
    end
  end

  always @(negedge clk) begin
    cmp_inst("nb", mq_nb, 3, 1'b0, nb_in_ready, nb_out_valid, nb_out_op, nb_hz_busy, int'(nb_count));
    cmp_inst("by", mq_by, 4, 1'b1, by_in_ready, by_out_valid, by_out_op, by_hz_busy, int'(by_count));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; hz_rs = '0;
    #3;
    chk("reset.count", nb_count, 0);
    chk("reset.out_valid", nb_out_valid, 0);
    chk("reset.in_ready", nb_in_ready, 1);
    chk("reset.hz_busy", nb_hz_busy, 0);
    #9 rst_n = 1'b1;

    // Reset mid-fill
    step();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_op = mkop(ADD, k + 1, k);
      step();
    end
    in_valid = 1'b0;
    chk("t1.nb_count_before", nb_count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t1.nb_count", nb_count, 0);
    chk("t1.by_count", by_count, 0);
    chk("t1.nb_out_valid", nb_out_valid, 0);
    chk("t1.nb_in_ready", nb_in_ready, 1);
    #2 rst_n = 1'b1;

    // Fill and drain
    step();
    hz_rs = {5'd3, 5'd1};
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_op = mkop(ADDI, k + 1, 50 + k);
      step();
    end
    in_valid = 1'b0;
    chk("t2.full_count", nb_count, 3);
    chk("t2.full_in_ready", nb_in_ready, 0);
    chk("t2.by_in_ready", by_in_ready, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2.pop_rdest", nb_out_op.rdest, k + 1);
      chk("t2.pop_count", nb_count, 3 - k);
      step();
    end
    chk("t2.empty_count", nb_count, 0);
    hz_rs = '0;

    // Full plus simultaneous pop
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_op = mkop(ADD, 10 + k, 10 + k);
      step();
    end
    in_op = mkop(ADD, 13, 13);
    out_ready = 1'b1;
    #1;
    chk("t3.full_in_ready", nb_in_ready, 0);
    chk("t3.full_out_valid", nb_out_valid, 1);
    step();
    chk("t3.after_pop_count", nb_count, 2);
    out_ready = 1'b0;
    step();
    chk("t3.after_push_count", nb_count, 3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("t3.drained", nb_count, 0);

    // Wrap with back-to-back push/pop
    in_valid = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      in_op = mkop(ADDI, 4, 200 + k);
      #1;
      if (k > 0) begin
        chk("t4.nb_imm", nb_out_op.imm_se, 200 + k - 1);
        chk("t4.nb_count", nb_count, 1);
      end
      chk("t4.by_imm", by_out_op.imm_se, 200 + k);
      chk("t4.by_count", by_count, 0);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("t4.nb_empty", nb_count, 0);

    // Bypass and NOP drop
    in_valid = 1'b1;
    in_op = mkop(LW, 7, 77);
    #1;
    chk("t5.by_out_valid", by_out_valid, 1);
    chk("t5.by_out_op", by_out_op.op, LW);
    chk("t5.by_count", by_count, 0);
    step();
    chk("t5.by_count_next", by_count, 0);
    chk("t5.nb_latency_valid", nb_out_valid, 1);
    chk("t5.nb_latency_op", nb_out_op.op, LW);
    in_op = mkop(NOP, 0, 0);
    #1;
    chk("t5.nop_in_ready", by_in_ready, 1);
    chk("t5.nop_out_valid", by_out_valid, 0);
    step();
    chk("t5.nop_by_count", by_count, 0);
    chk("t5.nop_nb_count", nb_count, 0);

    // Flush and hazards
    out_ready = 1'b0;
    in_op = mkop(ADD, 5, 1);
    step();
    in_op = mkop(ADD, 0, 2);
    step();
    in_valid = 1'b0;
    hz_rs = {5'd0, 5'd5};
    #1;
    chk("t6.nb_hz_busy", nb_hz_busy, 2'b01);
    chk("t6.by_hz_busy", by_hz_busy, 2'b01);
    flush = 1'b1;
    in_valid = 1'b1;
    in_op = mkop(ADD, 9, 3);
    out_ready = 1'b1;
    #1;
    chk("t6.flush_nb_out_valid", nb_out_valid, 0);
    chk("t6.flush_by_out_valid", by_out_valid, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    hz_rs = {5'd5, 5'd9};
    #1;
    chk("t6.nb_count", nb_count, 0);
    chk("t6.by_count", by_count, 0);
    chk("t6.nb_hz_busy_after", nb_hz_busy, 0);
    chk("t6.by_hz_busy_after", by_hz_busy, 0);
    chk("t6.nb_out_valid_after", nb_out_valid, 0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
